// File: rtl/ide_device_pio_if.sv
// ATA device-side bus bundle: host-facing IDE signals plus the sector backend handshake.
// The slave modport is the device view; master is the host/backend view.
interface ide_device_pio_if;
   logic        nidereset;
   logic [1:0]  ncs;
   logic [2:0]  da;
   logic        nior;
   logic        niow;
   logic [15:0] dd_in;
   logic [15:0] dd_out;
   logic        dd_oe;
   logic        intrq;
   logic        ndasp;
   logic        bk_req;
   logic        bk_write;
   logic        bk_ident;
   logic [27:0] bk_lba;
   logic        bk_ack;
   logic [15:0] bk_rdata;
   logic        bk_rnext;
   logic [15:0] bk_wdata;
   logic        bk_wstrobe;

   modport master (
      output nidereset, ncs, da, nior, niow, dd_in, bk_ack, bk_rdata,
      input  dd_out, dd_oe, intrq, ndasp, bk_req, bk_write, bk_ident, bk_lba,
             bk_rnext, bk_wdata, bk_wstrobe
   );

   modport slave (
      input  nidereset, ncs, da, nior, niow, dd_in, bk_ack, bk_rdata,
      output dd_out, dd_oe, intrq, ndasp, bk_req, bk_write, bk_ident, bk_lba,
             bk_rnext, bk_wdata, bk_wstrobe
   );
endinterface

// File: rtl/ide_device_pio.sv
// ATA PIO device responder: task file, READ/WRITE SECTORS and IDENTIFY command engine,
// and a word-streaming handshake to a sector backend.
module ide_device_pio #(
   parameter int SECTOR_WORDS = 256,
   parameter int SYNC_STAGES  = 2,
   parameter int RESET_CYCLES = 16
) (
   input logic             cpuclk7,
   input logic             reset,
   ide_device_pio_if.slave bus
);
   localparam int WCW = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
   localparam int RCW = $clog2(RESET_CYCLES + 1);

   localparam logic [2:0] S_RST       = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_RD_WAIT   = 3'd2;
   localparam logic [2:0] S_RD_XFER   = 3'd3;
   localparam logic [2:0] S_WR_XFER   = 3'd4;
   localparam logic [2:0] S_WR_COMMIT = 3'd5;

   logic [2:0]             state_q, state_d;
   logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
   logic [WCW-1:0]         wcnt_q, wcnt_d;
   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d, hr_sync_q, hr_sync_d;
   logic                   rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
   logic                   srst_q, srst_d, nien_q, nien_d, abrt_q, abrt_d;
   logic                   intrq_q, intrq_d, ident_q, ident_d;
   logic                   rnext_q, rnext_d, wstrobe_q, wstrobe_d;
   logic [1:0]             acc_cs_q, acc_cs_d;
   logic [2:0]             acc_da_q, acc_da_d;
   logic [15:0]            wlatch_q, wlatch_d, wdata_q, wdata_d;
   logic [7:0]             error_q, error_d, seccount_q, seccount_d;
   logic [7:0]             lba0_q, lba0_d, lba1_q, lba1_d, lba2_q, lba2_d, devhead_q, devhead_d;

   logic        rd_s, wr_s, hr_s, rd_rise, rd_fall, wr_rise, wr_fall;
   logic        rst_src, bsy, drq, set_irq, clr_irq;
   logic [7:0]  status;
   logic [27:0] lba_cur, lba_inc;
   logic [15:0] dd_out_c;

   assign rd_s    = rd_sync_q[SYNC_STAGES-1];
   assign wr_s    = wr_sync_q[SYNC_STAGES-1];
   assign hr_s    = hr_sync_q[SYNC_STAGES-1];
   assign rd_rise = rd_s & ~rd_prev_q;
   assign rd_fall = ~rd_s & rd_prev_q;
   assign wr_rise = wr_s & ~wr_prev_q;
   assign wr_fall = ~wr_s & wr_prev_q;
   assign rst_src = reset | ~hr_s | srst_q;
   assign bsy     = (state_q == S_RST) || (state_q == S_RD_WAIT) || (state_q == S_WR_COMMIT);
   assign drq     = (state_q == S_RD_XFER) || (state_q == S_WR_XFER);
   assign status  = {bsy, ~bsy, 1'b0, ~bsy, drq, 2'b00, abrt_q & (state_q == S_IDLE)};
   assign lba_cur = {devhead_q[3:0], lba2_q, lba1_q, lba0_q};
   assign lba_inc = lba_cur + 28'd1;

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      wcnt_d     = wcnt_q;
      rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], bus.nior};
      wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], bus.niow};
      hr_sync_d  = {hr_sync_q[SYNC_STAGES-2:0], bus.nidereset};
      rd_prev_d  = rd_s;
      wr_prev_d  = wr_s;
      srst_d     = srst_q;
      nien_d     = nien_q;
      abrt_d     = abrt_q;
      intrq_d    = intrq_q;
      ident_d    = ident_q;
      rnext_d    = 1'b0;
      wstrobe_d  = 1'b0;
      acc_cs_d   = acc_cs_q;
      acc_da_d   = acc_da_q;
      wlatch_d   = wlatch_q;
      wdata_d    = wdata_q;
      error_d    = error_q;
      seccount_d = seccount_q;
      lba0_d     = lba0_q;
      lba1_d     = lba1_q;
      lba2_d     = lba2_q;
      devhead_d  = devhead_q;
      set_irq    = 1'b0;
      clr_irq    = 1'b0;

      // Address and write data are frozen when the strobe is first seen low,
      // so late host bus changes cannot corrupt the edge-triggered side effects.
      if (rd_fall || wr_fall) begin
         acc_cs_d = bus.ncs;
         acc_da_d = bus.da;
      end
      if (wr_fall) wlatch_d = bus.dd_in;

      case (state_q)
         S_RST: begin
            if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
               state_d    = S_IDLE;
               error_d    = 8'h01;
               seccount_d = 8'h01;
               lba0_d     = 8'h01;
               lba1_d     = 8'h00;
               lba2_d     = 8'h00;
               devhead_d  = 8'h00;
               nien_d     = 1'b0;
               abrt_d     = 1'b0;
            end else begin
               rst_cnt_d = rst_cnt_q + RCW'(1);
            end
         end
         S_RD_WAIT: begin
            if (bus.bk_ack) begin
               state_d = S_RD_XFER;
               wcnt_d  = '0;
               set_irq = 1'b1;
            end
         end
         S_WR_COMMIT: begin
            if (bus.bk_ack) begin
               {devhead_d[3:0], lba2_d, lba1_d, lba0_d} = lba_inc;
               seccount_d = seccount_q - 8'd1;
               set_irq    = 1'b1;
               wcnt_d     = '0;
               state_d    = (seccount_q == 8'd1) ? S_IDLE : S_WR_XFER;
            end
         end
         default: ;
      endcase

      if (wr_rise) begin
         if (acc_cs_q == 2'b01 && acc_da_q == 3'd6) begin
            nien_d = wlatch_q[1];
            srst_d = wlatch_q[2];
         end else if (acc_cs_q == 2'b10) begin
            if (acc_da_q == 3'd0) begin
               if (state_q == S_WR_XFER) begin
                  wdata_d   = wlatch_q;
                  wstrobe_d = 1'b1;
                  if (wcnt_q == WCW'(SECTOR_WORDS - 1)) begin
                     wcnt_d  = '0;
                     state_d = S_WR_COMMIT;
                  end else begin
                     wcnt_d = wcnt_q + WCW'(1);
                  end
               end
            end else if (!bsy) begin
               case (acc_da_q)
                  3'd2: seccount_d = wlatch_q[7:0];
                  3'd3: lba0_d     = wlatch_q[7:0];
                  3'd4: lba1_d     = wlatch_q[7:0];
                  3'd5: lba2_d     = wlatch_q[7:0];
                  3'd6: devhead_d  = wlatch_q[7:0];
                  3'd7: begin
                     if (state_q == S_IDLE) begin
                        clr_irq = 1'b1;
                        error_d = 8'h00;
                        abrt_d  = 1'b0;
                        wcnt_d  = '0;
                        case (wlatch_q[7:0])
                           8'h20: begin ident_d = 1'b0; state_d = S_RD_WAIT; end
                           8'h30: begin ident_d = 1'b0; state_d = S_WR_XFER; end
                           8'hEC: begin ident_d = 1'b1; state_d = S_RD_WAIT; end
                           default: begin
                              error_d = 8'h04;
                              abrt_d  = 1'b1;
                              set_irq = 1'b1;
                           end
                        endcase
                     end
                  end
                  default: ;
               endcase
            end
         end
      end

      if (rd_rise && acc_cs_q == 2'b10) begin
         if (acc_da_q == 3'd7) clr_irq = 1'b1;
         if (acc_da_q == 3'd0 && state_q == S_RD_XFER) begin
            rnext_d = 1'b1;
            if (wcnt_q == WCW'(SECTOR_WORDS - 1)) begin
               wcnt_d = '0;
               if (ident_q) begin
                  state_d = S_IDLE;
               end else begin
                  {devhead_d[3:0], lba2_d, lba1_d, lba0_d} = lba_inc;
                  seccount_d = seccount_q - 8'd1;
                  state_d    = (seccount_q == 8'd1) ? S_IDLE : S_RD_WAIT;
               end
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
      end

      // Raising the interrupt wins over a same-cycle status-read clear.
      if (set_irq)      intrq_d = 1'b1;
      else if (clr_irq) intrq_d = 1'b0;

      if (rst_src) begin
         state_d   = S_RST;
         rst_cnt_d = '0;
         wcnt_d    = '0;
         intrq_d   = 1'b0;
         ident_d   = 1'b0;
         rnext_d   = 1'b0;
         wstrobe_d = 1'b0;
      end
      if (reset || !hr_s) srst_d = 1'b0;
   end

   always_ff @(posedge cpuclk7) begin
      if (reset) begin
         state_q   <= S_RST;
         rst_cnt_q <= '0;
         wcnt_q    <= '0;
         rd_sync_q <= '1;
         wr_sync_q <= '1;
         hr_sync_q <= '1;
         rd_prev_q <= 1'b1;
         wr_prev_q <= 1'b1;
         srst_q    <= 1'b0;
         nien_q    <= 1'b0;
         abrt_q    <= 1'b0;
         intrq_q   <= 1'b0;
         ident_q   <= 1'b0;
         rnext_q   <= 1'b0;
         wstrobe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         wcnt_q    <= wcnt_d;
         rd_sync_q <= rd_sync_d;
         wr_sync_q <= wr_sync_d;
         hr_sync_q <= hr_sync_d;
         rd_prev_q <= rd_prev_d;
         wr_prev_q <= wr_prev_d;
         srst_q    <= srst_d;
         nien_q    <= nien_d;
         abrt_q    <= abrt_d;
         intrq_q   <= intrq_d;
         ident_q   <= ident_d;
         rnext_q   <= rnext_d;
         wstrobe_q <= wstrobe_d;
      end
   end

   // Task file and latched bus data: the reset state loads the signature on exit.
   always_ff @(posedge cpuclk7) begin
      acc_cs_q   <= acc_cs_d;
      acc_da_q   <= acc_da_d;
      wlatch_q   <= wlatch_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
      seccount_q <= seccount_d;
      lba0_q     <= lba0_d;
      lba1_q     <= lba1_d;
      lba2_q     <= lba2_d;
      devhead_q  <= devhead_d;
   end

   always_comb begin
      dd_out_c = 16'h00FF;
      if (bus.ncs == 2'b10) begin
         case (bus.da)
            3'd0:    dd_out_c = bus.bk_rdata;
            3'd1:    dd_out_c = {8'h00, error_q};
            3'd2:    dd_out_c = {8'h00, seccount_q};
            3'd3:    dd_out_c = {8'h00, lba0_q};
            3'd4:    dd_out_c = {8'h00, lba1_q};
            3'd5:    dd_out_c = {8'h00, lba2_q};
            3'd6:    dd_out_c = {8'h00, devhead_q};
            default: dd_out_c = {8'h00, status};
         endcase
      end else if (bus.ncs == 2'b01 && bus.da == 3'd6) begin
         dd_out_c = {8'h00, status};
      end
   end

   assign bus.dd_out     = dd_out_c;
   assign bus.dd_oe      = ~reset & ~bus.nior & ((bus.ncs == 2'b10) || (bus.ncs == 2'b01));
   assign bus.intrq      = intrq_q & ~nien_q & ~rst_src;
   assign bus.ndasp      = ~(bsy | drq) | rst_src;
   assign bus.bk_req     = ((state_q == S_RD_WAIT) || (state_q == S_WR_COMMIT)) & ~rst_src;
   assign bus.bk_write   = (state_q == S_WR_COMMIT);
   assign bus.bk_ident   = ident_q;
   assign bus.bk_lba     = lba_cur;
   assign bus.bk_rnext   = rnext_q & ~rst_src;
   assign bus.bk_wdata   = wdata_q;
   assign bus.bk_wstrobe = wstrobe_q & ~rst_src;
endmodule

// File: tb/tb_ide_device_pio.sv
// Directed bench for ide_device_pio: table-driven task-file accesses plus
// hand-written read, write, abort, soft-reset, IDENTIFY and LBA-wrap sequences.
module tb_ide_device_pio;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ide_device_pio_if bif ();

   ide_device_pio dut (
      .cpuclk7 (clk),
      .reset   (reset),
      .bus     (bif)
   );

   int checks = 0;
   int errors = 0;
   int rnext_cnt = 0;
   int wstb_cnt = 0;
   int wdata_bad = 0;
   logic [15:0] exp_wdata = 16'h0000;

   assign bif.bk_rdata = rnext_cnt[15:0];

   always @(posedge clk) begin
      if (bif.bk_rnext === 1'b1) rnext_cnt++;
      if (bif.bk_wstrobe === 1'b1) begin
         wstb_cnt++;
         if (bif.bk_wdata !== exp_wdata) wdata_bad++;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  cs;
      logic [2:0]  da;
      bit          wr;
      logic [15:0] d;
      logic [15:0] exp;
      bit          exp_oe;
   } vec_t;
   vec_t vt [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", name, act, exp);
      end
   endtask

   task automatic host_wr(input logic [1:0] cs, input logic [2:0] a, input logic [15:0] d);
      bif.ncs = cs; bif.da = a; bif.dd_in = d; bif.niow = 1'b0;
      repeat (3) @(negedge clk);
      bif.niow = 1'b1;
      repeat (4) @(negedge clk);
      bif.ncs = 2'b11;
   endtask

   task automatic host_rd(input logic [1:0] cs, input logic [2:0] a,
                          output logic [15:0] d, output logic oe);
      bif.ncs = cs; bif.da = a; bif.nior = 1'b0;
      repeat (3) @(negedge clk);
      d = bif.dd_out; oe = bif.dd_oe;
      bif.nior = 1'b1;
      repeat (4) @(negedge clk);
      bif.ncs = 2'b11;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] cs, input logic [2:0] a,
                         input logic [15:0] exp);
      logic [15:0] d; logic oe;
      host_rd(cs, a, d, oe);
      chk(name, d, exp);
   endtask

   task automatic do_ack(input string nm, input logic [27:0] exp_lba, input logic exp_wr);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (bif.bk_req === 1'b1) begin ok = 1; break; end
         @(negedge clk);
      end
      chk({nm, "_req"}, ok, 1);
      chk({nm, "_lba"}, bif.bk_lba, exp_lba);
      chk({nm, "_bkwrite"}, bif.bk_write, exp_wr);
      rd_chk({nm, "_busy_status"}, 2'b01, 3'd6, 16'h0080);
      bif.bk_ack = 1'b1;
      @(negedge clk);
      bif.bk_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk({nm, "_req_drop"}, bif.bk_req, 0);
   endtask

   task automatic read_words(input string nm, input int n);
      int bad = 0;
      int start = rnext_cnt;
      logic [15:0] d; logic oe;
      for (int i = 0; i < n; i++) begin
         host_rd(2'b10, 3'd0, d, oe);
         if (d !== 16'(start + i)) bad++;
      end
      chk({nm, "_word_errs"}, bad, 0);
      chk({nm, "_rnext"}, rnext_cnt - start, n);
   endtask

   initial begin
      logic [15:0] d;
      logic oe;

      bif.nidereset = 1'b1; bif.ncs = 2'b10; bif.da = 3'd7; bif.nior = 1'b0;
      bif.niow = 1'b1; bif.dd_in = 16'h0; bif.bk_ack = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dd_oe", bif.dd_oe, 0);
      chk("rst_intrq", bif.intrq, 0);
      chk("rst_ndasp", bif.ndasp, 1);
      chk("rst_bk_req", bif.bk_req, 0);
      chk("rst_bk_pulses", {bif.bk_rnext, bif.bk_wstrobe}, 0);
      bif.nior = 1'b1; bif.ncs = 2'b11;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Hardware reset from the host
      bif.nidereset = 1'b0;
      repeat (3) @(negedge clk);
      bif.nidereset = 1'b1;
      repeat (4) @(negedge clk);
      rd_chk("hwrst_bsy", 2'b01, 3'd6, 16'h0080);
      chk("hwrst_ndasp_busy", bif.ndasp, 0);
      repeat (20) @(negedge clk);
      chk("hwrst_intrq", bif.intrq, 0);
      chk("hwrst_ndasp_idle", bif.ndasp, 1);

      vt[0]  = '{2'b10, 3'd1, 1'b0, 16'h0000, 16'h0001, 1'b1};
      vt[1]  = '{2'b10, 3'd2, 1'b0, 16'h0000, 16'h0001, 1'b1};
      vt[2]  = '{2'b10, 3'd3, 1'b0, 16'h0000, 16'h0001, 1'b1};
      vt[3]  = '{2'b10, 3'd4, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vt[4]  = '{2'b10, 3'd5, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vt[5]  = '{2'b10, 3'd6, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vt[6]  = '{2'b10, 3'd7, 1'b0, 16'h0000, 16'h0050, 1'b1};
      vt[7]  = '{2'b01, 3'd6, 1'b0, 16'h0000, 16'h0050, 1'b1};
      vt[8]  = '{2'b01, 3'd0, 1'b0, 16'h0000, 16'h00FF, 1'b1};
      vt[9]  = '{2'b00, 3'd7, 1'b0, 16'h0000, 16'h00FF, 1'b0};
      vt[10] = '{2'b10, 3'd2, 1'b1, 16'h0002, 16'h0000, 1'b0};
      vt[11] = '{2'b10, 3'd3, 1'b1, 16'h0010, 16'h0000, 1'b0};
      vt[12] = '{2'b10, 3'd4, 1'b1, 16'h0000, 16'h0000, 1'b0};
      vt[13] = '{2'b10, 3'd5, 1'b1, 16'h0000, 16'h0000, 1'b0};
      vt[14] = '{2'b10, 3'd6, 1'b1, 16'h00E0, 16'h0000, 1'b0};
      vt[15] = '{2'b10, 3'd1, 1'b1, 16'h0055, 16'h0000, 1'b0};
      vt[16] = '{2'b10, 3'd2, 1'b0, 16'h0000, 16'h0002, 1'b1};
      vt[17] = '{2'b10, 3'd3, 1'b0, 16'h0000, 16'h0010, 1'b1};
      vt[18] = '{2'b10, 3'd6, 1'b0, 16'h0000, 16'h00E0, 1'b1};
      vt[19] = '{2'b10, 3'd1, 1'b0, 16'h0000, 16'h0001, 1'b1};

      for (int i = 0; i < 20; i++) begin
         if (vt[i].wr) begin
            host_wr(vt[i].cs, vt[i].da, vt[i].d);
         end else begin
            host_rd(vt[i].cs, vt[i].da, d, oe);
            chk($sformatf("vec%0d_data", i), d, vt[i].exp);
            chk($sformatf("vec%0d_oe", i), oe, vt[i].exp_oe);
         end
      end

      // READ SECTORS, two sectors starting at LBA 0x10
      host_wr(2'b10, 3'd7, 16'h0020);
      do_ack("rd_s0", 28'h0000010, 1'b0);
      chk("rd_s0_intrq", bif.intrq, 1);
      rd_chk("rd_s0_status", 2'b10, 3'd7, 16'h0058);
      chk("rd_s0_intrq_clr", bif.intrq, 0);
      read_words("rd_s0", 256);
      do_ack("rd_s1", 28'h0000011, 1'b0);
      chk("rd_s1_intrq", bif.intrq, 1);
      rd_chk("rd_s1_status", 2'b10, 3'd7, 16'h0058);
      chk("rd_s1_intrq_clr", bif.intrq, 0);
      read_words("rd_s1", 256);
      rd_chk("rd_final_status", 2'b10, 3'd7, 16'h0050);
      rd_chk("rd_final_seccount", 2'b10, 3'd2, 16'h0000);
      rd_chk("rd_final_lba0", 2'b10, 3'd3, 16'h0012);

      // WRITE SECTORS, one sector of 0xA5A5
      host_wr(2'b10, 3'd2, 16'h0001);
      host_wr(2'b10, 3'd7, 16'h0030);
      rd_chk("wr_drq_status", 2'b10, 3'd7, 16'h0058);
      exp_wdata = 16'hA5A5;
      wstb_cnt = 0;
      for (int i = 0; i < 256; i++) host_wr(2'b10, 3'd0, 16'hA5A5);
      chk("wr_strobes", wstb_cnt, 256);
      chk("wr_wdata_errs", wdata_bad, 0);
      do_ack("wr_commit", 28'h0000012, 1'b1);
      rd_chk("wr_done_alt", 2'b01, 3'd6, 16'h0050);
      chk("wr_done_intrq", bif.intrq, 1);
      rd_chk("wr_done_status", 2'b10, 3'd7, 16'h0050);
      chk("wr_done_intrq_clr", bif.intrq, 0);

      // Unknown opcode aborts
      host_wr(2'b10, 3'd7, 16'h0091);
      rd_chk("abrt_alt", 2'b01, 3'd6, 16'h0051);
      rd_chk("abrt_error", 2'b10, 3'd1, 16'h0004);
      chk("abrt_intrq", bif.intrq, 1);
      rd_chk("abrt_status", 2'b10, 3'd7, 16'h0051);
      chk("abrt_intrq_clr", bif.intrq, 0);

      // Soft reset in the middle of a sector read
      host_wr(2'b10, 3'd2, 16'h0001);
      host_wr(2'b10, 3'd7, 16'h0020);
      do_ack("srst_rd", 28'h0000013, 1'b0);
      read_words("srst_rd", 100);
      host_wr(2'b01, 3'd6, 16'h0004);
      chk("srst_bk_req", bif.bk_req, 0);
      chk("srst_ndasp", bif.ndasp, 1);
      rd_chk("srst_bsy", 2'b01, 3'd6, 16'h0080);
      host_wr(2'b01, 3'd6, 16'h0000);
      repeat (22) @(negedge clk);
      rd_chk("srst_status", 2'b01, 3'd6, 16'h0050);
      rd_chk("srst_error", 2'b10, 3'd1, 16'h0001);
      rd_chk("srst_seccount", 2'b10, 3'd2, 16'h0001);
      rd_chk("srst_lba0", 2'b10, 3'd3, 16'h0001);
      rd_chk("srst_lba1", 2'b10, 3'd4, 16'h0000);
      rd_chk("srst_devhead", 2'b10, 3'd6, 16'h0000);

      // IDENTIFY with nIEN set
      host_wr(2'b01, 3'd6, 16'h0002);
      host_wr(2'b10, 3'd7, 16'h00EC);
      do_ack("ident", 28'h0000001, 1'b0);
      chk("ident_flag", bif.bk_ident, 1);
      chk("ident_intrq_masked", bif.intrq, 0);
      rd_chk("ident_alt", 2'b01, 3'd6, 16'h0058);
      read_words("ident", 256);
      rd_chk("ident_done_alt", 2'b01, 3'd6, 16'h0050);
      host_wr(2'b01, 3'd6, 16'h0000);
      chk("ident_pending_unmasked", bif.intrq, 1);

      // LBA wrap at the top of the 28-bit space
      host_wr(2'b10, 3'd2, 16'h0002);
      host_wr(2'b10, 3'd3, 16'h00FF);
      host_wr(2'b10, 3'd4, 16'h00FF);
      host_wr(2'b10, 3'd5, 16'h00FF);
      host_wr(2'b10, 3'd6, 16'h00EF);
      host_wr(2'b10, 3'd7, 16'h0020);
      chk("wrap_cmd_intrq_clr", bif.intrq, 0);
      do_ack("wrap_s0", 28'hFFFFFFF, 1'b0);
      read_words("wrap_s0", 256);
      do_ack("wrap_s1", 28'h0000000, 1'b0);
      read_words("wrap_s1", 256);
      rd_chk("wrap_status", 2'b10, 3'd7, 16'h0050);
      rd_chk("wrap_devhead", 2'b10, 3'd6, 16'h00E0);
      rd_chk("wrap_lba0", 2'b10, 3'd3, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
